mips_writeback_regfile: RTL and testbench
=========================================

Name: mips_writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: takes the MEM/WB register outputs, selects the writeback value and commits it to a 32x32 general register file.
- Serves the ID stage with two combinational read ports, using write-through bypass so ID sees a same-cycle WB write.
- Exposes the current WB write to the forwarding unit.
- Keeps registered last-write and write-count observation outputs for debug and verification.

Parameters:
- DATA_WIDTH, 32, width of register data, PC and ALU result.
- ADDR_WIDTH, 5, register index width; file depth = 2**ADDR_WIDTH.
- RA_REG, 31, destination index forced when wb_jal=1 ($ra).
- SP_INIT, 32'h0000_03FC, reset value of register 29 (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- wb_read_data  in  DATA_WIDTH  memory load data from MEM/WB.
- wb_alu_result  in  DATA_WIDTH  ALU result from MEM/WB.
- wb_pc  in  DATA_WIDTH  return address (PC+4) from MEM/WB, written unchanged on jal.
- wb_write_register  in  ADDR_WIDTH  destination index from MEM/WB.
- wb_jal  in  1  jal writeback select.
- wb_mem_to_reg  in  1  1 = write load data, 0 = write ALU result.
- wb_reg_write  in  1  writeback enable.
- rd_addr_a  in  ADDR_WIDTH  read port A index.
- rd_data_a  out  DATA_WIDTH  read port A data (combinational).
- rd_addr_b  in  ADDR_WIDTH  read port B index.
- rd_data_b  out  DATA_WIDTH  read port B data (combinational).
- fwd_valid  out  1  current cycle performs a real write (combinational).
- fwd_addr  out  ADDR_WIDTH  effective write index (combinational).
- fwd_data  out  DATA_WIDTH  effective write data (combinational).
- last_wr_addr  out  ADDR_WIDTH  index of most recent committed write (registered).
- last_wr_data  out  DATA_WIDTH  data of most recent committed write (registered).
- wr_count  out  32  number of committed writes (registered).

Behaviour:
- eff_addr = wb_jal ? RA_REG : wb_write_register.
- eff_data selection, in priority order: wb_jal -> wb_pc; else wb_mem_to_reg -> wb_read_data; else wb_alu_result.
- we = wb_reg_write & (eff_addr != 0) & ~reset. wb_jal with wb_reg_write=0 performs no write.
- fwd_valid = we; fwd_addr = eff_addr; fwd_data = eff_data. These are driven even when we=0; consumers gate on fwd_valid.
- Write commit: on posedge clk with we=1, regs[eff_addr] <= eff_data. Latency 1 cycle into storage, 0 cycles to read ports through bypass.
- Read port A (B identical):
  - rd_addr_a == 0 -> 0.
  - else we & (rd_addr_a == eff_addr) -> eff_data (bypass).
  - else regs[rd_addr_a].
- Register 0 is never stored; it always reads 0, even if eff_addr=0 with wb_reg_write=1. Such a write is discarded and is not counted.
- Both ports may address the same register; both return the identical value.
- Observation outputs: on posedge with we=1, last_wr_addr <= eff_addr, last_wr_data <= eff_data, and wr_count <= wr_count + 1. wr_count wraps from 0xFFFF_FFFF to 0. They hold when we=0.
- Reset (posedge clk with reset=1):
  - All registers clear to 0, except register 29 under the optional feature.
  - last_wr_addr=0, last_wr_data=0, wr_count=0.
  - Reset takes priority over a simultaneous write; that write is dropped.
  - During reset, fwd_valid=0 and the bypass is suppressed, so reads return array contents.
- Reset mid-stream: the cycle after reset deasserts accepts writes normally, and the pipeline register presents zeroed controls.

Optional Feature:
- Macro: REGFILE_SP_INIT_EN.
- Defined: reset loads register 29 with SP_INIT, so $sp reads 32'h0000_03FC after reset; all other registers are 0.
- Undefined: register 29 resets to 0 like the rest; the SP_INIT parameter is unused.

Test Plan:
- Reset, then read all 32 indices -> all 0 (with REGFILE_SP_INIT_EN, index 29 = 32'h3FC); wr_count=0.
- ALU write: wb_reg_write=1, wb_mem_to_reg=0, wb_write_register=8, wb_alu_result=32'hDEAD_BEEF, rd_addr_a=8 in the same cycle -> rd_data_a=32'hDEAD_BEEF via bypass; next cycle with controls low -> still 32'hDEAD_BEEF, last_wr_addr=8, wr_count=1.
- Load vs jal priority: wb_jal=1, wb_mem_to_reg=1, wb_reg_write=1, wb_write_register=5, wb_pc=32'h0040_0010 -> register 31 = 32'h0040_0010; register 5 unchanged.
- $zero: write index 0 with data 32'h1234 -> rd_data_b at index 0 = 0, fwd_valid=0, wr_count unchanged.
- Reset collision: reset=1 with a write of 32'hAAAA to index 3 -> after the edge, register 3 = 0 and wr_count=0; the same write the cycle after deassert -> register 3 = 32'hAAAA.
- Count wrap: force 2**32 writes (or preload via hierarchical force to 0xFFFF_FFFF) plus one write -> wr_count=0.

Source files
------------

// File: rtl/mips_writeback_regfile.sv
// MIPS writeback stage and 32x32 register file: selects the writeback value, commits it,
// serves two bypassed read ports, feeds forwarding and keeps debug observation registers.
// Optional feature: define REGFILE_SP_INIT_EN to reset register 29 ($sp) to SP_INIT.
module mips_writeback_regfile #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 5,
   parameter int                    RA_REG     = 31,
   parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0000_03FC
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wb_read_data,
   input  logic [DATA_WIDTH-1:0] wb_alu_result,
   input  logic [DATA_WIDTH-1:0] wb_pc,
   input  logic [ADDR_WIDTH-1:0] wb_write_register,
   input  logic                  wb_jal,
   input  logic                  wb_mem_to_reg,
   input  logic                  wb_reg_write,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  fwd_valid,
   output logic [ADDR_WIDTH-1:0] fwd_addr,
   output logic [DATA_WIDTH-1:0] fwd_data,
   output logic [ADDR_WIDTH-1:0] last_wr_addr,
   output logic [DATA_WIDTH-1:0] last_wr_data,
   output logic [31:0]           wr_count
);

   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam int SP_REG = 29;

`ifdef REGFILE_SP_INIT_EN
   localparam bit SP_EN = 1'b1;
`else
   localparam bit SP_EN = 1'b0;
`endif

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [ADDR_WIDTH-1:0] eff_addr;
   logic [DATA_WIDTH-1:0] eff_data;
   logic                  we;

   // jal overrides both the destination index and the data source.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      eff_addr = wb_write_register;
      eff_data = wb_alu_result;
      if (wb_jal) begin
         eff_addr = ADDR_WIDTH'(RA_REG);
         eff_data = wb_pc;
      end else if (wb_mem_to_reg) begin
         eff_data = wb_read_data;
      end
      we = wb_reg_write && !reset && (eff_addr != '0);
   end

   assign fwd_valid = we;
   assign fwd_addr  = eff_addr;
   assign fwd_data  = eff_data;

   always_comb begin
      rd_data_a = regs[rd_addr_a];
      if (rd_addr_a == '0) begin
         rd_data_a = '0;
      end else if (we && (rd_addr_a == eff_addr)) begin
         rd_data_a = eff_data;
      end
   end

   always_comb begin
      rd_data_b = regs[rd_addr_b];
      if (rd_addr_b == '0) begin
         rd_data_b = '0;
      end else if (we && (rd_addr_b == eff_addr)) begin
         rd_data_b = eff_data;
      end
   end

   // NOTE: the storage array is cleared by reset because architectural state must read 0
   // afterwards; this rules out a plain RAM macro, which is acceptable at 32 entries.
   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= (SP_EN && (i == SP_REG)) ? SP_INIT : '0;
         end
         last_wr_addr <= '0;
         last_wr_data <= '0;
         wr_count     <= '0;
      end else if (we) begin
         regs[eff_addr] <= eff_data;
         last_wr_addr   <= eff_addr;
         last_wr_data   <= eff_data;
         wr_count       <= wr_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_mips_writeback_regfile.sv
// Self-checking bench for mips_writeback_regfile: directed scenarios followed by random
// traffic, all compared against an array-based reference model of the register file.
module tb_mips_writeback_regfile;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_read_data, wb_alu_result, wb_pc;
   logic [4:0]  wb_write_register;
   logic        wb_jal, wb_mem_to_reg, wb_reg_write;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [31:0] rd_data_a, rd_data_b;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic [4:0]  last_wr_addr;
   logic [31:0] last_wr_data;
   logic [31:0] wr_count;

`ifdef REGFILE_SP_INIT_EN
   localparam logic [31:0] SP_RST = 32'h0000_03FC;
`else
   localparam logic [31:0] SP_RST = 32'h0;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state.
   logic [31:0] m_regs [32];
   logic [4:0]  m_last_addr;
   logic [31:0] m_last_data;
   logic [31:0] m_count;

   mips_writeback_regfile dut (
      .clk               (clk),
      .reset             (reset),
      .wb_read_data      (wb_read_data),
      .wb_alu_result     (wb_alu_result),
      .wb_pc             (wb_pc),
      .wb_write_register (wb_write_register),
      .wb_jal            (wb_jal),
      .wb_mem_to_reg     (wb_mem_to_reg),
      .wb_reg_write      (wb_reg_write),
      .rd_addr_a         (rd_addr_a),
      .rd_data_a         (rd_data_a),
      .rd_addr_b         (rd_addr_b),
      .rd_data_b         (rd_data_b),
      .fwd_valid         (fwd_valid),
      .fwd_addr          (fwd_addr),
      .fwd_data          (fwd_data),
      .last_wr_addr      (last_wr_addr),
      .last_wr_data      (last_wr_data),
      .wr_count          (wr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[29]  = SP_RST;
      m_last_addr = 5'd0;
      m_last_data = 32'h0;
      m_count     = 32'h0;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a, input logic w,
                                          input logic [4:0] ea, input logic [31:0] ed);
      if (a == 5'd0) return 32'h0;
      if (w && a == ea) return ed;
      return m_regs[a];
   endfunction

   task automatic drive(input logic rst, input logic jal, input logic m2r, input logic rw,
                        input logic [4:0] wreg, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc,
                        input logic [4:0] ra, input logic [4:0] rb);
      @(negedge clk);
      reset             = rst;
      wb_jal            = jal;
      wb_mem_to_reg     = m2r;
      wb_reg_write      = rw;
      wb_write_register = wreg;
      wb_alu_result     = alu;
      wb_read_data      = ld;
      wb_pc             = pc;
      rd_addr_a         = ra;
      rd_addr_b         = rb;
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, ra, rb);
   endtask

   // Checks combinational outputs mid-cycle, clocks once, updates the model, checks registers.
   task automatic cycle();
      logic [4:0]  ea;
      logic [31:0] ed;
      logic        w;
      ea = wb_jal ? 5'd31 : wb_write_register;
      ed = wb_jal ? wb_pc : (wb_mem_to_reg ? wb_read_data : wb_alu_result);
      w  = wb_reg_write && !reset && (ea != 5'd0);
      #1;
      check("fwd_valid", {31'h0, fwd_valid}, {31'h0, w});
      check("fwd_addr", {27'h0, fwd_addr}, {27'h0, ea});
      check("fwd_data", fwd_data, ed);
      check("rd_data_a", rd_data_a, m_read(rd_addr_a, w, ea, ed));
      check("rd_data_b", rd_data_b, m_read(rd_addr_b, w, ea, ed));
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else if (w) begin
         m_regs[ea]  = ed;
         m_last_addr = ea;
         m_last_data = ed;
         m_count     = m_count + 32'd1;
      end
      #1;
      check("last_wr_addr", {27'h0, last_wr_addr}, {27'h0, m_last_addr});
      check("last_wr_data", last_wr_data, m_last_data);
      check("wr_count", wr_count, m_count);
   endtask

   initial begin
      // Initial reset: array contents are unknown beforehand, so nothing is compared yet.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
      @(posedge clk);
      model_reset();

      // All 32 indices read back their reset values.
      for (int i = 0; i < 16; i++) begin
         idle(5'(2 * i), 5'(2 * i + 1));
         #1;
         check("rst_read_a", rd_data_a, (2 * i == 29) ? SP_RST : 32'h0);
         check("rst_read_b", rd_data_b, (2 * i + 1 == 29) ? SP_RST : 32'h0);
         cycle();
      end
      check("rst_count", wr_count, 32'h0);

      // ALU write with same-cycle bypass, then committed value.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'h5555_0000, 32'h0, 5'd8, 5'd9);
      #1 check("alu_bypass", rd_data_a, 32'hDEAD_BEEF);
      cycle();
      idle(5'd8, 5'd0);
      #1 check("alu_commit", rd_data_a, 32'hDEAD_BEEF);
      check("alu_last_addr", {27'h0, last_wr_addr}, 32'd8);
      check("alu_count", wr_count, 32'd1);
      cycle();

      // jal outranks mem_to_reg and redirects the write to $ra.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'h1111, 32'h2222, 32'h0040_0010, 5'd31, 5'd5);
      cycle();
      idle(5'd31, 5'd5);
      #1 check("jal_r31", rd_data_a, 32'h0040_0010);
      check("jal_r5", rd_data_b, 32'h0);
      cycle();

      // jal without reg_write writes nothing.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0BAD_0BAD, 5'd31, 5'd0);
      cycle();

      // Load write.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000_0001, 32'hCAFE_F00D, 32'h0, 5'd12, 5'd12);
      cycle();

      // Write to $zero is discarded and not counted.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd0, 5'd0);
      #1 check("zero_read_b", rd_data_b, 32'h0);
      check("zero_fwd_valid", {31'h0, fwd_valid}, 32'h0);
      cycle();
      check("zero_count", wr_count, 32'd3);

      // Reset takes priority over a simultaneous write; the write succeeds after deassert.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_AAAA, 32'h0, 32'h0, 5'd3, 5'd8);
      cycle();
      idle(5'd3, 5'd8);
      #1 check("coll_r3", rd_data_a, 32'h0);
      check("coll_count", wr_count, 32'h0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_AAAA, 32'h0, 32'h0, 5'd1, 5'd3);
      cycle();
      idle(5'd3, 5'd29);
      #1 check("coll_r3_after", rd_data_a, 32'h0000_AAAA);
      cycle();

      // Random traffic with occasional reset.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wreg;
         wreg = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
               1'($urandom), ($urandom_range(0, 3) != 0), wreg,
               $urandom, $urandom, $urandom,
               ($urandom_range(0, 2) == 0) ? wreg : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
         cycle();
      end

      // Counter wrap: preload the counter, then one real write.
      dut.wr_count = 32'hFFFF_FFFF;
      m_count      = 32'hFFFF_FFFF;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 32'h0BEE_F00D, 32'h0, 32'h0, 5'd17, 5'd0);
      cycle();
      check("wrap_count", wr_count, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
